multi_voice_i2s_player: RTL and testbench
=========================================

Name: multi_voice_i2s_player

Overview:
- Parametrised successor to the two-voice speaker path. NUM_VOICES square-wave tone voices, each with its own half-period divider, amplitude and left/right pan mask.
- Voices are mixed with saturation into signed stereo samples. Samples are latched once per frame and serialised as I2S (MCLK/LRCK/SCK/SDIN) to the Pmod I2S DAC.
- Sits between the music/note sequencer and the board audio pins.

Parameters:
- NUM_VOICES, 4, number of tone voices (1..8).
- DIV_W, 22, width of each voice's half-period divider.
- SAMPLE_W, 16, signed PCM sample width (≤ 31).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = play; 0 = latch silence at the next frame boundary.
- note_div  in  NUM_VOICES*DIV_W  half-period in clk cycles per voice; voice i at [i*DIV_W +: DIV_W]; 0 = voice off.
- amp  in  NUM_VOICES*(SAMPLE_W-1)  unsigned amplitude per voice.
- pan_left  in  NUM_VOICES  bit i = voice i contributes to left.
- pan_right  in  NUM_VOICES  bit i = voice i contributes to right.
- audio_mclk  out  1  I2S master clock, clk/4.
- audio_lrck  out  1  word select, clk/512; 0 = left.
- audio_sck  out  1  bit clock, clk/8 (64 SCK per frame).
- audio_sdin  out  1  serial data.
- frame_tick  out  1  one-cycle pulse when new samples are latched.

Behaviour:
- **Frame counter.** cnt[8:0] is free-running 0..511 and wraps to 0. Reset sets it to 0.
- **Derived outputs.** mclk=cnt[1], sck=cnt[2], lrck=cnt[8], slot=cnt[7:3]. All four outputs are registered from cnt, so each lags cnt by exactly one clk. After reset all are 0.
- **Voice counter.** Per voice, counter vc (DIV_W bits) and wave bit w.
  - Reset: vc=0, w=0.
  - note_div==0: vc=0, w=0, contribution 0.
  - Otherwise, if vc >= note_div-1 then vc←0 and w←~w; else vc←vc+1.
  - A divider change takes effect immediately. Using >= means lowering note_div below vc wraps on the next cycle.
  - note_div==1 toggles w every clk.
- **Contribution.** Voice i gives +amp_i when w=1 and -amp_i when w=0. It is 0 when note_div==0. It adds to left if pan_left[i] and to right if pan_right[i].
- **Mixing.** Sum in SAMPLE_W+3 signed bits, then saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- **Sample latch.** On the cycle cnt==511, hold_l/hold_r ← saturated sums, or 0 if enable==0. frame_tick=1 on the following cycle (cnt==0) only. Reset: hold_l=hold_r=0, frame_tick=0.
- **Serialisation (I2S, MSB-first, one-SCK delay).** In each half-frame (lrck=0 left, lrck=1 right):
  - slot 0 is 0;
  - slots 1..SAMPLE_W carry hold bit SAMPLE_W-slot;
  - remaining slots are 0.
  - sdin is registered and aligned with lrck/sck, so it changes only while sck is low: sck falls at cnt[2:0]=0 and rises at cnt[2:0]=4.
- **Reset mid-frame.** Everything returns to reset values on the next clk edge. The first valid frame starts at cnt==0 with hold=0, so outputs are silent until the first latch.
- **enable deassert mid-frame.** The current frame still completes with the old samples. Silence starts from the next frame.

Decomposition:
- Package audio_pkg holds:
  - FRAME_CLKS=512, SLOTS_PER_HALF=32, MCLK_BIT=1, SCK_BIT=2, LRCK_BIT=8;
  - a saturate function parametrised by width.
- Sub-module tone_voice holds one voice's divider counter, wave bit and signed contribution output. It is instantiated NUM_VOICES times in a generate loop.
- Mixer, latch and serialiser stay in the top module.

Test Plan:
- **Reset.** Hold rst 3 cycles mid-frame -> all outputs 0 on the cycle after the rst edge; the first frame_tick appears 512 cycles after release; sdin is all zeros for the first frame.
- **Single voice.** note_div0=4, amp0=1000, pan_left0=1, others off -> w0 toggles every 4 clk; hold_l ∈ {1000,-1000} (0x03E8/0xFC18) on each frame_tick; hold_r=0; decoded left word matches hold_l bit-exactly, MSB in slot 1.
- **Saturation.** 4 voices, note_div=200000, amp=16000, all panned left and right, first frame -> all w=0 -> left=right=-32768 (0x8000). After 200000 clk all w=1 -> 32767 (0x7FFF).
- **Voice off / pan.** note_div1=0 with amp1=5000 -> contributes 0. pan_right only on voice 2 (amp 300, note_div 7) -> left=0, right=±300.
- **Clock ratios.** Free run 2048 clk -> mclk period 4, sck period 8, lrck period 512, lrck edges coincide with sck falling edges, frame_tick exactly once per 512 clk.
- **Enable drop.** Deassert enable at cnt=100 -> the current frame still serialises the old sample; the next frame's hold_l=hold_r=0. Reassert -> samples resume at the following frame_tick.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared frame-timing constants and sample saturation for the I2S audio path.
package audio_pkg;

    localparam int FRAME_CLKS     = 512;
    localparam int SLOTS_PER_HALF = 32;
    localparam int MCLK_BIT       = 1;
    localparam int SCK_BIT        = 2;
    localparam int LRCK_BIT       = 8;
    localparam int CNT_W          = $clog2(FRAME_CLKS);
    localparam int SAT_W          = 40;

    // Clamp a wide signed value into the range of a signed word of 'width' bits.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = {{(SAT_W-1){1'b0}}, 1'b1} << (width - 1);
        max_v = max_v - 1;
        min_v = ~max_v;
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: half-period divider, wave bit and signed +/-amp contribution.
module tone_voice #(
    parameter int DIV_W    = 22,
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIV_W-1:0]           note_div,
    input  logic [SAMPLE_W-2:0]        amp,
    output logic signed [SAMPLE_W-1:0] contrib
);

    logic [DIV_W-1:0]           vc;
    logic                       wave;
    logic signed [SAMPLE_W-1:0] mag;

    // '>=' lets a lowered divider wrap immediately instead of running to overflow.
    always_ff @(posedge clk) begin
        if (rst || note_div == '0) begin
            vc   <= '0;
            wave <= 1'b0;
        end else if (vc >= note_div - DIV_W'(1)) begin
            vc   <= '0;
            wave <= ~wave;
        end else begin
            vc <= vc + DIV_W'(1);
        end
    end

    assign mag = signed'({1'b0, amp});

    always_comb begin
        contrib = '0;
        if (note_div != '0) begin
            contrib = wave ? mag : -mag;
        end
    end

endmodule

// File: rtl/multi_voice_i2s_player.sv
// NUM_VOICES tone voices mixed with saturation into stereo samples, latched per frame
// and serialised as I2S (one-SCK delay, MSB first) for the Pmod I2S DAC.
module multi_voice_i2s_player
    import audio_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 22,
    parameter int SAMPLE_W   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [NUM_VOICES*DIV_W-1:0]        note_div,
    input  logic [NUM_VOICES*(SAMPLE_W-1)-1:0] amp,
    input  logic [NUM_VOICES-1:0]              pan_left,
    input  logic [NUM_VOICES-1:0]              pan_right,
    output logic                               audio_mclk,
    output logic                               audio_lrck,
    output logic                               audio_sck,
    output logic                               audio_sdin,
    output logic                               frame_tick
);

    localparam int MIX_W  = SAMPLE_W + 3;
    localparam int SLOT_W = $clog2(SLOTS_PER_HALF);

    logic [CNT_W-1:0]           cnt;
    logic signed [SAMPLE_W-1:0] contrib [NUM_VOICES];
    logic signed [MIX_W-1:0]    sum_l;
    logic signed [MIX_W-1:0]    sum_r;
    logic signed [SAMPLE_W-1:0] sat_l;
    logic signed [SAMPLE_W-1:0] sat_r;
    logic signed [SAMPLE_W-1:0] hold_l;
    logic signed [SAMPLE_W-1:0] hold_r;
    logic [SLOT_W-1:0]          slot;
    logic [SLOT_W-1:0]          bit_idx;
    logic [SAMPLE_W-1:0]        word;
    logic                       sdin_next;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        tone_voice #(
            .DIV_W   (DIV_W),
            .SAMPLE_W(SAMPLE_W)
        ) u_voice (
            .clk     (clk),
            .rst     (rst),
            .note_div(note_div[i*DIV_W +: DIV_W]),
            .amp     (amp[i*(SAMPLE_W-1) +: (SAMPLE_W-1)]),
            .contrib (contrib[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (pan_left[i]) begin
                sum_l = sum_l + MIX_W'(contrib[i]);
            end
            if (pan_right[i]) begin
                sum_r = sum_r + MIX_W'(contrib[i]);
            end
        end
    end

    assign sat_l = SAMPLE_W'(saturate(SAT_W'(sum_l), SAMPLE_W));
    assign sat_r = SAMPLE_W'(saturate(SAT_W'(sum_r), SAMPLE_W));

    // Latch on the last count of the frame so the new words start exactly at cnt==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_l     <= '0;
            hold_r     <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (cnt == CNT_W'(FRAME_CLKS - 1));
            if (cnt == CNT_W'(FRAME_CLKS - 1)) begin
                hold_l <= enable ? sat_l : '0;
                hold_r <= enable ? sat_r : '0;
            end
        end
    end

    always_comb begin
        slot      = cnt[LRCK_BIT-1:SCK_BIT+1];
        word      = cnt[LRCK_BIT] ? hold_r : hold_l;
        bit_idx   = SLOT_W'(SAMPLE_W) - slot;
        sdin_next = 1'b0;
        if (slot != '0 && int'(slot) <= SAMPLE_W) begin
            sdin_next = |(word & (SAMPLE_W'(1) << bit_idx));
        end
    end

    // All pins are registered from the same cnt value, keeping sdin aligned to sck/lrck.
    always_ff @(posedge clk) begin
        if (rst) begin
            audio_mclk <= 1'b0;
            audio_sck  <= 1'b0;
            audio_lrck <= 1'b0;
            audio_sdin <= 1'b0;
        end else begin
            audio_mclk <= cnt[MCLK_BIT];
            audio_sck  <= cnt[SCK_BIT];
            audio_lrck <= cnt[LRCK_BIT];
            audio_sdin <= sdin_next;
        end
    end

endmodule

// File: tb/tb_multi_voice_i2s_player.sv
// Scoreboard bench: frame-level reference model predicts each decoded I2S frame.
module tb_multi_voice_i2s_player;

    localparam int NUM_VOICES = 4;
    localparam int DIV_W      = 22;
    localparam int SAMPLE_W   = 16;
    localparam int AMP_W      = SAMPLE_W - 1;

    logic                          clk;
    logic                          rst;
    logic                          enable;
    logic [NUM_VOICES*DIV_W-1:0]   note_div;
    logic [NUM_VOICES*AMP_W-1:0]   amp;
    logic [NUM_VOICES-1:0]         pan_left;
    logic [NUM_VOICES-1:0]         pan_right;
    logic                          audio_mclk;
    logic                          audio_lrck;
    logic                          audio_sck;
    logic                          audio_sdin;
    logic                          frame_tick;

    typedef struct {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } frame_t;

    frame_t exp_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;

    int div_v   [NUM_VOICES];
    int amp_v   [NUM_VOICES];
    bit pan_l_v [NUM_VOICES];
    bit pan_r_v [NUM_VOICES];

    multi_voice_i2s_player #(
        .NUM_VOICES(NUM_VOICES),
        .DIV_W     (DIV_W),
        .SAMPLE_W  (SAMPLE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .note_div  (note_div),
        .amp       (amp),
        .pan_left  (pan_left),
        .pan_right (pan_right),
        .audio_mclk(audio_mclk),
        .audio_lrck(audio_lrck),
        .audio_sck (audio_sck),
        .audio_sdin(audio_sdin),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Voice with half-period d started from w=0: after n clocks w = (n / d) mod 2.
    // Latch m samples the waves after 511 + 512*m clocks since reset release.
    function automatic logic [SAMPLE_W-1:0] modelSample(input int m, input bit right);
        longint n;
        longint sum;
        longint max_v;
        n     = 511 + 512 * longint'(m);
        sum   = 0;
        max_v = (longint'(1) << (SAMPLE_W - 1)) - 1;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (div_v[i] != 0 && (right ? pan_r_v[i] : pan_l_v[i])) begin
                sum += ((n / div_v[i]) % 2 == 1) ? amp_v[i] : -amp_v[i];
            end
        end
        if (sum > max_v) sum = max_v;
        if (sum < -max_v - 1) sum = -max_v - 1;
        return SAMPLE_W'(sum);
    endfunction

    function automatic bit enAt(input int k, input int off_a, input int off_b);
        return !(k >= off_a && k < off_b);
    endfunction

    task automatic clearVoices();
        for (int i = 0; i < NUM_VOICES; i++) begin
            div_v[i]   = 0;
            amp_v[i]   = 0;
            pan_l_v[i] = 0;
            pan_r_v[i] = 0;
        end
    endtask

    task automatic driveConfig();
        for (int i = 0; i < NUM_VOICES; i++) begin
            note_div[i*DIV_W +: DIV_W] = DIV_W'(div_v[i]);
            amp[i*AMP_W +: AMP_W]      = AMP_W'(amp_v[i]);
            pan_left[i]                = pan_l_v[i];
            pan_right[i]               = pan_r_v[i];
        end
    endtask

    // Idle mid-frame, reset for 3 clocks, then run 'frames' latches with enable
    // low for clock indices [off_a, off_b) counted from the first clock after release.
    task automatic applyStimulus(input int frames, input int off_a, input int off_b,
                                 input int idle);
        int     last;
        int     phase_err;
        int     tick_err;
        int     align_err;
        int     ticks;
        logic   prev_lrck;
        logic   prev_sck;
        frame_t f;
        last      = 512 * frames + 510;
        phase_err = 0;
        tick_err  = 0;
        align_err = 0;
        ticks     = 0;
        for (int i = 0; i < idle; i++) begin
            @(posedge clk);
            #1;
        end
        driveConfig();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_tick}, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        exp_q.delete();
        f.l = '0;
        f.r = '0;
        exp_q.push_back(f);
        for (int m = 0; m < frames; m++) begin
            f.l = enAt(511 + 512 * m, off_a, off_b) ? modelSample(m, 1'b0) : '0;
            f.r = enAt(511 + 512 * m, off_a, off_b) ? modelSample(m, 1'b1) : '0;
            exp_q.push_back(f);
        end
        rst       = 1'b0;
        enable    = enAt(0, off_a, off_b);
        prev_lrck = 1'b0;
        prev_sck  = 1'b0;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (audio_mclk !== k[1] || audio_sck !== k[2] || audio_lrck !== k[8])
                phase_err++;
            if (frame_tick !== ((k % 512) == 511)) tick_err++;
            if (frame_tick === 1'b1) ticks++;
            if (audio_lrck !== prev_lrck && !(prev_sck === 1'b1 && audio_sck === 1'b0))
                align_err++;
            prev_lrck = audio_lrck;
            prev_sck  = audio_sck;
            enable    = enAt(k + 1, off_a, off_b);
        end
        checkOutput("clock_phase_errors", phase_err, 0);
        checkOutput("frame_tick_timing_errors", tick_err, 0);
        checkOutput("frame_tick_count", ticks, frames);
        checkOutput("lrck_sck_align_errors", align_err, 0);
        checkOutput("frames_left_in_queue", exp_q.size(), 0);
    endtask

    // Monitor: decode I2S halves on sck rising edges and compare complete frames.
    initial begin
        logic        prev_sck;
        logic        cur_lrck;
        logic        have_left;
        logic [31:0] sh;
        logic [31:0] left_w;
        logic [31:0] pad_mask;
        int          nbits;
        frame_t      e;
        pad_mask  = ~(((32'd1 << SAMPLE_W) - 32'd1) << (31 - SAMPLE_W));
        prev_sck  = 1'b0;
        cur_lrck  = 1'b0;
        have_left = 1'b0;
        sh        = '0;
        left_w    = '0;
        nbits     = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_sck  = 1'b0;
                cur_lrck  = 1'b0;
                have_left = 1'b0;
                nbits     = 0;
            end else begin
                if (prev_sck === 1'b0 && audio_sck === 1'b1) begin
                    if (audio_lrck !== cur_lrck) begin
                        cur_lrck = audio_lrck;
                        nbits    = 0;
                    end
                    sh = {sh[30:0], audio_sdin};
                    nbits++;
                    if (nbits == 32) begin
                        if (cur_lrck == 1'b0) begin
                            left_w    = sh;
                            have_left = 1'b1;
                        end else if (have_left) begin
                            have_left = 1'b0;
                            if (exp_q.size() == 0) begin
                                checkOutput("unexpected_frame", 32'd1, 32'd0);
                            end else begin
                                e = exp_q.pop_front();
                                checkOutput("left_word", 32'(left_w[30 -: SAMPLE_W]), 32'(e.l));
                                checkOutput("right_word", 32'(sh[30 -: SAMPLE_W]), 32'(e.r));
                                checkOutput("padding_bits", (left_w & pad_mask) | (sh & pad_mask),
                                            32'd0);
                            end
                        end
                    end
                end
                prev_sck = audio_sck;
            end
        end
    end

    initial begin
        int frames;
        int off_a;
        int off_b;
        rst       = 1'b1;
        enable    = 1'b0;
        note_div  = '0;
        amp       = '0;
        pan_left  = '0;
        pan_right = '0;

        // Single voice: steady square wave on the left only.
        clearVoices();
        div_v[0] = 4; amp_v[0] = 1000; pan_l_v[0] = 1;
        applyStimulus(3, -1, -1, 0);

        // Four loud voices all low in the first frames: negative clip.
        clearVoices();
        for (int i = 0; i < NUM_VOICES; i++) begin
            div_v[i] = 200000; amp_v[i] = 16000; pan_l_v[i] = 1; pan_r_v[i] = 1;
        end
        applyStimulus(2, -1, -1, 137);

        // Same voices toggling every clock: high at every latch, positive clip.
        for (int i = 0; i < NUM_VOICES; i++) div_v[i] = 1;
        applyStimulus(2, -1, -1, 250);

        // Voice off with nonzero amp, plus a right-only voice.
        clearVoices();
        div_v[1] = 0; amp_v[1] = 5000; pan_l_v[1] = 1; pan_r_v[1] = 1;
        div_v[2] = 7; amp_v[2] = 300;  pan_r_v[2] = 1;
        applyStimulus(3, -1, -1, 61);

        // Enable dropped at cnt=100 of frame 1, restored mid frame 2.
        clearVoices();
        div_v[0] = 4; amp_v[0] = 1000; pan_l_v[0] = 1; pan_r_v[0] = 1;
        applyStimulus(4, 612, 1300, 199);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                div_v[i]   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1500));
                amp_v[i]   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2000))
                                                         : int'($urandom_range(0, (1 << AMP_W) - 1));
                pan_l_v[i] = 1'($urandom_range(0, 1));
                pan_r_v[i] = 1'($urandom_range(0, 1));
            end
            frames = int'($urandom_range(1, 3));
            off_a  = -1;
            off_b  = -1;
            if ($urandom_range(0, 1) == 1) begin
                off_a = int'($urandom_range(0, 512 * frames));
                off_b = off_a + int'($urandom_range(1, 700));
            end
            applyStimulus(frames, off_a, off_b, int'($urandom_range(1, 300)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
